// File: rtl/regfile_pkg.sv
// Shared constants and clear-FSM state encoding for the parametrised register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: owns the sweep counter, Busy and the dropped-write flag,
// and drives the array's clear write port while a sweep is in progress.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              reg_wr,
    output logic              idle,
    output logic              busy,
    output logic              wr_drop,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << ADDR_W) - 1);

    fsm_state_e       state_r;
    fsm_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             busy_r;
    logic             busy_s;
    logic             wr_drop_r;
    logic             wr_drop_s;

    // State, counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            busy_r    <= 1'b0;
            wr_drop_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            busy_r    <= busy_s;
            wr_drop_r <= wr_drop_s;
        end
    end

    // Next-state logic; a write coinciding with the start edge or the sweep is dropped.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        busy_s    = busy_r;
        wr_drop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_s   = ST_CLEAR;
                    cnt_s     = '0;
                    busy_s    = 1'b1;
                    wr_drop_s = reg_wr;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            ST_CLEAR: begin
                wr_drop_s = reg_wr;
                cnt_s     = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_IDX) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign idle     = (state_r == ST_IDLE);
    assign clr_we   = (state_r == ST_CLEAR);
    assign clr_addr = cnt_r[ADDR_W-1:0];
    assign busy     = busy_r;
    assign wr_drop  = wr_drop_r;

endmodule

// File: rtl/param_register_file.sv
// Parametrised multi-read-port register file with bulk-clear sweep and debug read port.
// Optional write-through forwarding on the read ports: define REGFILE_BYPASS_EN.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     RegWr,
    input  logic [ADDR_W-1:0]        RW,
    input  logic [DATA_W-1:0]        BusW,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*DATA_W-1:0] BusR,
    input  logic                     Clear,
    output logic                     Busy,
    output logic                     WrDrop,
    input  logic [ADDR_W-1:0]        DbgAddr,
    output logic [DATA_W-1:0]        DbgData
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              idle_s;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] dbg_s;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .clear    (Clear),
        .reg_wr   (RegWr),
        .idle     (idle_s),
        .busy     (Busy),
        .wr_drop  (WrDrop),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    // Writes to hardwired entry 0 vanish silently; the start-of-sweep cycle also blocks writes.
    assign wr_en_s = RegWr && idle_s && !Clear && !(ZERO_EN && (RW == '0));

    // Storage array; the sweep owns the write port while it runs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clr_we_s) begin
            mem_r[clr_addr_s] <= '0;
        end else if (wr_en_s) begin
            mem_r[RW] <= BusW;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [DATA_W-1:0] rd_s;

        assign ra_s = RA[g*ADDR_W +: ADDR_W];

        // Combinational read port, optionally forwarding the in-flight write.
        always_comb begin
            rd_s = mem_r[ra_s];
            if (ZERO_EN && (ra_s == '0)) begin
                rd_s = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_en_s && (RW == ra_s)) begin
                rd_s = BusW;
`endif
            end else begin
                rd_s = mem_r[ra_s];
            end
        end

        assign BusR[g*DATA_W +: DATA_W] = rd_s;
    end

    // Debug port always shows the stored value, never the forwarded one.
    always_comb begin
        dbg_s = mem_r[DbgAddr];
        if (ZERO_EN && (DbgAddr == '0)) begin
            dbg_s = '0;
        end else begin
            dbg_s = mem_r[DbgAddr];
        end
    end

    assign DbgData = dbg_s;

endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench for param_register_file (NUM_RD=3, 32x32, ZERO_REG=1).
`timescale 1ns/1ps
module tb_param_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 3;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     Clk;
    logic                     Rst_n;
    logic                     RegWr;
    logic [ADDR_W-1:0]        RW;
    logic [DATA_W-1:0]        BusW;
    logic [NUM_RD*ADDR_W-1:0] RA;
    logic [NUM_RD*DATA_W-1:0] BusR;
    logic                     Clear;
    logic                     Busy;
    logic                     WrDrop;
    logic [ADDR_W-1:0]        DbgAddr;
    logic [DATA_W-1:0]        DbgData;

    int checks = 0;
    int errors = 0;
    int cyc;

    param_register_file #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .RegWr   (RegWr),
        .RW      (RW),
        .BusW    (BusW),
        .RA      (RA),
        .BusR    (BusR),
        .Clear   (Clear),
        .Busy    (Busy),
        .WrDrop  (WrDrop),
        .DbgAddr (DbgAddr),
        .DbgData (DbgData)
    );

    initial Clk = 1'b0;
    // Free-running clock.
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst_n = 1'b0; RegWr = 1'b0; RW = 5'd0; BusW = 32'd0;
        RA = 15'd0; Clear = 1'b0; DbgAddr = 5'd0;

        // reset state
        RA = {5'd0, 5'd31, 5'd5}; DbgAddr = 5'd5;
        tick();
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_wrdrop", 64'(WrDrop), 64'd0);
        chk("rst_rd0", 64'(BusR[31:0]), 64'd0);
        chk("rst_rd1", 64'(BusR[63:32]), 64'd0);
        chk("rst_dbg", 64'(DbgData), 64'd0);
        #2 Rst_n = 1'b1;
        tick();

        // 1: write/read r5
        RegWr = 1'b1; RW = 5'd5; BusW = 32'hDEADBEEF; RA = {5'd0, 5'd0, 5'd5};
        #1;
        chk("wr_same_cycle", 64'(BusR[31:0]), (BYP ? 64'hDEADBEEF : 64'd0));
        chk("dbg_same_cycle", 64'(DbgData), 64'd0);
        tick();
        RegWr = 1'b0;
        #1;
        chk("wr_next_cycle", 64'(BusR[31:0]), 64'hDEADBEEF);
        chk("wr_dbg", 64'(DbgData), 64'hDEADBEEF);
        chk("wr_nodrop", 64'(WrDrop), 64'd0);

        // 2: zero register
        RegWr = 1'b1; RW = 5'd0; BusW = 32'hFFFFFFFF; RA = {5'd0, 5'd0, 5'd0}; DbgAddr = 5'd0;
        #1;
        chk("zero_same_cycle", 64'(BusR[31:0]), 64'd0);
        tick();
        RegWr = 1'b0;
        #1;
        chk("zero_rd", 64'(BusR[31:0]), 64'd0);
        chk("zero_dbg", 64'(DbgData), 64'd0);
        chk("zero_nodrop", 64'(WrDrop), 64'd0);

        // 3: fill all entries with index+1, then sweep
        for (int i = 0; i < 32; i++) begin
            RegWr = 1'b1; RW = 5'(i); BusW = 32'(i + 1);
            tick();
        end
        RegWr = 1'b0; RA = {5'd0, 5'd31, 5'd1}; DbgAddr = 5'd5;
        #1;
        chk("fill_r1", 64'(BusR[31:0]), 64'd2);
        chk("fill_r31", 64'(BusR[63:32]), 64'd32);
        chk("fill_dbg5", 64'(DbgData), 64'd6);
        chk("fill_idle", 64'(Busy), 64'd0);

        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        cyc = 0;
        while (Busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 11) begin
                RA = {5'd0, 5'd10, 5'd9};
                #1;
                chk("mid_r9", 64'(BusR[31:0]), 64'd0);
                chk("mid_r10", 64'(BusR[63:32]), 64'd11);
            end
            if (cyc == 15) begin
                RegWr = 1'b1; RW = 5'd7; BusW = 32'h1234;
            end
            if (cyc == 16) begin
                RegWr = 1'b0;
                chk("drop_flag", 64'(WrDrop), 64'd1);
            end
            if (cyc == 17) begin
                chk("drop_flag_clr", 64'(WrDrop), 64'd0);
            end
            if (cyc == 20) Clear = 1'b1;
            if (cyc == 21) Clear = 1'b0;
            tick();
        end
        chk("sweep_no_timeout", 64'(cyc < 100), 64'd1);
        chk("busy_cycles", 64'(cyc), 64'd32);
        RA = {5'd1, 5'd10, 5'd31}; DbgAddr = 5'd7;
        #1;
        chk("post_r31", 64'(BusR[31:0]), 64'd0);
        chk("post_r10", 64'(BusR[63:32]), 64'd0);
        chk("post_r1", 64'(BusR[95:64]), 64'd0);
        chk("post_r7", 64'(DbgData), 64'd0);

        // 5: async reset mid-sweep, with a write dropped in the start cycle
        RegWr = 1'b1; RW = 5'd3; BusW = 32'h55;
        tick();
        RW = 5'd20; BusW = 32'h66;
        tick();
        Clear = 1'b1; RW = 5'd4; BusW = 32'h77;
        tick();
        Clear = 1'b0; RegWr = 1'b0;
        #1;
        chk("start_busy", 64'(Busy), 64'd1);
        chk("start_drop", 64'(WrDrop), 64'd1);
        tick();
        tick();
        RA = {5'd4, 5'd20, 5'd3};
        #2;
        chk("pre_rst_r3", 64'(BusR[31:0]), 64'h55);
        chk("pre_rst_r20", 64'(BusR[63:32]), 64'h66);
        chk("pre_rst_r4", 64'(BusR[95:64]), 64'd0);
        Rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(Busy), 64'd0);
        chk("arst_r3", 64'(BusR[31:0]), 64'd0);
        chk("arst_r20", 64'(BusR[63:32]), 64'd0);
        #1 Rst_n = 1'b1;
        tick();
        chk("arst_idle", 64'(Busy), 64'd0);

        // 6: forwarding (or not) on ports 0 and 2; debug port never forwards
        RegWr = 1'b1; RW = 5'd3; BusW = 32'hA5A5A5A5;
        RA = {5'd3, 5'd4, 5'd3}; DbgAddr = 5'd3;
        #1;
        chk("byp_rd0", 64'(BusR[31:0]), (BYP ? 64'hA5A5A5A5 : 64'd0));
        chk("byp_rd1", 64'(BusR[63:32]), 64'd0);
        chk("byp_rd2", 64'(BusR[95:64]), (BYP ? 64'hA5A5A5A5 : 64'd0));
        chk("byp_dbg", 64'(DbgData), 64'd0);
        tick();
        RW = 5'd0; BusW = 32'h12345678; RA = {5'd3, 5'd0, 5'd0};
        #1;
        chk("byp_zero", 64'(BusR[31:0]), 64'd0);
        chk("landed_rd2", 64'(BusR[95:64]), 64'hA5A5A5A5);
        chk("landed_dbg", 64'(DbgData), 64'hA5A5A5A5);
        RegWr = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
